// File: rtl/servo_ramp.sv
// Three-axis servo slew limiter: each pos_* output moves toward its latched target by at most
// STEP counts per ramp tick. Define SERVO_RAMP_CLAMP_EN to saturate targets to [POS_MIN, POS_MAX].
module servo_ramp #(
    parameter int unsigned TICK_DIV  = 50000,
    parameter logic [15:0] STEP      = 16'd1,
    parameter logic [15:0] RESET_POS = 16'd90,
    parameter logic [15:0] POS_MIN   = 16'd0,
    parameter logic [15:0] POS_MAX   = 16'd180
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] target_x_i,
    input  logic [15:0] target_y_i,
    input  logic [15:0] target_z_i,
    input  logic        target_valid_i,
    output logic [15:0] pos_x_o,
    output logic [15:0] pos_y_o,
    output logic [15:0] pos_z_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    typedef enum logic [0:0] {StIdle, StRamp} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0][15:0]  pos_q, pos_d;
    logic [2:0][15:0]  tgt_q, tgt_d;
    logic [2:0][15:0]  tgt_in;
    logic              done_q, done_d;
    logic              tick;

    // Moves one axis toward its target; the 17-bit difference keeps the compare wrap-free.
    function automatic logic [15:0] step_toward(input logic [15:0] pos, input logic [15:0] tgt);
        logic [16:0] diff;
        logic [15:0] res;
        if (tgt >= pos) begin
            diff = {1'b0, tgt} - {1'b0, pos};
            res  = (diff <= {1'b0, STEP}) ? tgt : pos + STEP;
        end else begin
            diff = {1'b0, pos} - {1'b0, tgt};
            res  = (diff <= {1'b0, STEP}) ? tgt : pos - STEP;
        end
        return res;
    endfunction

`ifdef SERVO_RAMP_CLAMP_EN
    function automatic logic [15:0] clamp_pos(input logic [15:0] v);
        logic [15:0] res;
        res = v;
        if (v < POS_MIN) res = POS_MIN;
        if (v > POS_MAX) res = POS_MAX;
        return res;
    endfunction

    always_comb begin
        tgt_in[0] = clamp_pos(target_x_i);
        tgt_in[1] = clamp_pos(target_y_i);
        tgt_in[2] = clamp_pos(target_z_i);
    end
`else
    logic [31:0] unused_bounds;
    assign unused_bounds = {POS_MIN, POS_MAX};

    always_comb begin
        tgt_in[0] = target_x_i;
        tgt_in[1] = target_y_i;
        tgt_in[2] = target_z_i;
    end
`endif

    // Free-running tick divider, never restarted by a new target.
    assign tick  = (cnt_q == CntMax);
    assign cnt_d = tick ? '0 : cnt_q + CntW'(1);

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        tgt_d   = tgt_q;
        done_d  = 1'b0;
        if (state_q == StRamp && tick) begin
            for (int i = 0; i < 3; i++) begin
                pos_d[i] = step_toward(pos_q[i], tgt_q[i]);
            end
            // A target arriving on the same edge keeps the ramp alive and suppresses done.
            if (pos_d == tgt_q && !target_valid_i) begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
        end
        if (target_valid_i) begin
            tgt_d   = tgt_in;
            state_d = StRamp;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pos_q   <= {3{RESET_POS}};
            tgt_q   <= {3{RESET_POS}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            tgt_q   <= tgt_d;
            done_q  <= done_d;
        end
    end

    assign pos_x_o = pos_q[0];
    assign pos_y_o = pos_q[1];
    assign pos_z_o = pos_q[2];
    assign busy_o  = (state_q == StRamp);
    assign done_o  = done_q;

endmodule

// File: tb/tb_servo_ramp.sv
// Scoreboard bench for servo_ramp: three instances (STEP=1, STEP=5, near-top-of-range STEP=4).
module tb_servo_ramp;

    logic        clk;
    logic        rst_n;
    logic [15:0] tx, ty, tz;
    logic [2:0]  vld;

    logic [15:0] px [3];
    logic [15:0] py [3];
    logic [15:0] pz [3];
    logic        busy [3];
    logic        done [3];

    servo_ramp #(.TICK_DIV(4), .STEP(16'd1), .RESET_POS(16'd90), .POS_MIN(16'd0),
                 .POS_MAX(16'd180)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .target_x_i(tx), .target_y_i(ty), .target_z_i(tz),
        .target_valid_i(vld[0]), .pos_x_o(px[0]), .pos_y_o(py[0]), .pos_z_o(pz[0]),
        .busy_o(busy[0]), .done_o(done[0]));

    servo_ramp #(.TICK_DIV(4), .STEP(16'd5), .RESET_POS(16'd90), .POS_MIN(16'd0),
                 .POS_MAX(16'd180)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .target_x_i(tx), .target_y_i(ty), .target_z_i(tz),
        .target_valid_i(vld[1]), .pos_x_o(px[1]), .pos_y_o(py[1]), .pos_z_o(pz[1]),
        .busy_o(busy[1]), .done_o(done[1]));

    servo_ramp #(.TICK_DIV(4), .STEP(16'd4), .RESET_POS(16'd65530), .POS_MIN(16'd0),
                 .POS_MAX(16'hFFFF)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .target_x_i(tx), .target_y_i(ty), .target_z_i(tz),
        .target_valid_i(vld[2]), .pos_x_o(px[2]), .pos_y_o(py[2]), .pos_z_o(pz[2]),
        .busy_o(busy[2]), .done_o(done[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Entry: {pad, dut index, x, y, z, busy, done}
    logic [63:0] exp_q [$];
    logic [63:0] prev  [3];

    function automatic logic [63:0] pack_ev(input int k, input logic [15:0] x, input logic [15:0] y,
                                            input logic [15:0] z, input logic b, input logic d);
        logic [1:0] kk;
        kk = k[1:0];
        return {12'd0, kk, x, y, z, b, d};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push(input int k, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] z, input logic b, input logic d);
        exp_q.push_back(pack_ev(k, x, y, z, b, d));
    endtask

    // Monitor: an output event is any pos change or a done pulse.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic [63:0] cur;
            logic [63:0] e;
            cur = pack_ev(k, px[k], py[k], pz[k], busy[k], done[k]);
            if (rst_n && (cur[49:2] != prev[k][49:2] || done[k])) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_event: got %h, expected no event (t=%0t)", cur, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("event", cur, e);
                end
            end
            prev[k] = cur;
        end
    end

    task automatic issue(input int k, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] z);
        @(negedge clk);
        tx = x; ty = y; tz = z;
        vld[k] = 1'b1;
        @(negedge clk);
        vld = '0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d events still pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_pos_x(input int k, input logic [15:0] val, input int budget);
        int n;
        n = 0;
        while (px[k] != val && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (px[k] != val) begin
            n_checks++;
            $display("FAIL wait_pos_x: got %0d, expected %0d within %0d cycles", px[k], val, budget);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        vld   = '0;
        tx = '0; ty = '0; tz = '0;
        for (int k = 0; k < 3; k++) prev[k] = '0;
        repeat (3) @(negedge clk);
        check("reset_pos_x", 64'(px[0]), 64'd90);
        check("reset_busy", 64'(busy[0]), 64'd0);
        check("reset_done", 64'(done[0]), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Basic ramp
        push(0, 91, 90, 89, 1, 0);
        push(0, 92, 90, 88, 1, 0);
        push(0, 93, 90, 88, 0, 1);
        issue(0, 93, 90, 88);
        drain(200);
        check("basic_busy_after", 64'(busy[0]), 64'd0);

        // Back to 90
        push(0, 92, 90, 89, 1, 0);
        push(0, 91, 90, 90, 1, 0);
        push(0, 90, 90, 90, 0, 1);
        issue(0, 90, 90, 90);
        drain(200);

        // Retarget mid-ramp
        push(0, 91, 90, 90, 1, 0);
        push(0, 92, 90, 90, 1, 0);
        issue(0, 100, 90, 90);
        wait_pos_x(0, 92, 200);
        for (int v = 91; v >= 86; v--) push(0, 16'(v), 90, 90, 1, 0);
        push(0, 85, 90, 90, 0, 1);
        issue(0, 85, 90, 90);
        drain(400);

        // Tick and target_valid on the same edge
        push(0, 86, 90, 90, 1, 0);
        issue(0, 87, 90, 90);
        wait_pos_x(0, 86, 200);
        push(0, 87, 90, 90, 1, 0);
        push(0, 86, 91, 90, 1, 0);
        push(0, 85, 92, 90, 1, 0);
        push(0, 84, 93, 90, 1, 0);
        push(0, 83, 94, 90, 1, 0);
        push(0, 82, 95, 90, 1, 0);
        push(0, 81, 95, 90, 1, 0);
        push(0, 80, 95, 90, 0, 1);
        repeat (3) @(negedge clk);
        tx = 80; ty = 95; tz = 90;
        vld[0] = 1'b1;
        @(negedge clk);
        vld = '0;
        check("simul_pos_x", 64'(px[0]), 64'd87);
        check("simul_busy", 64'(busy[0]), 64'd1);
        check("simul_done", 64'(done[0]), 64'd0);
        drain(400);

        // Target equal to current position
        push(0, 80, 95, 90, 0, 1);
        issue(0, 80, 95, 90);
        check("same_tgt_busy", 64'(busy[0]), 64'd1);
        drain(200);

        // STEP=5: no overshoot, exact multiple, partial last step
        push(1, 92, 85, 95, 1, 0);
        push(1, 92, 80, 97, 0, 1);
        issue(1, 92, 80, 97);
        drain(200);

        // Top of range: saturates at 16'hFFFF without wrapping
        push(2, 16'd65534, 16'd65528, 16'd65530, 1, 0);
        push(2, 16'd65535, 16'd65528, 16'd65530, 0, 1);
        issue(2, 16'hFFFF, 16'd65528, 16'd65530);
        drain(200);
        push(2, 16'd65535, 16'd65528, 16'd65530, 0, 1);
        issue(2, 16'hFFFF, 16'd65528, 16'd65530);
        drain(200);

        // Asynchronous reset mid-ramp, then counter restart
        for (int v = 81; v <= 92; v++) push(0, 16'(v), 95, 90, 1, 0);
        issue(0, 100, 95, 90);
        wait_pos_x(0, 92, 400);
        @(negedge clk);
        exp_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pos_x", 64'(px[0]), 64'd90);
        check("arst_pos_y", 64'(py[0]), 64'd90);
        check("arst_pos_z", 64'(pz[0]), 64'd90);
        check("arst_busy", 64'(busy[0]), 64'd0);
        check("arst_done", 64'(done[0]), 64'd0);
        check("arst_c_pos_x", 64'(px[2]), 64'd65530);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tx = 91; ty = 90; tz = 90;
        vld[0] = 1'b1;
        push(0, 91, 90, 90, 0, 1);
        @(posedge clk);
        #1 vld = '0;
        check("rel_busy", 64'(busy[0]), 64'd1);
        repeat (2) @(posedge clk);
        #1 check("rel_pos_before_tick", 64'(px[0]), 64'd90);
        @(posedge clk);
        #1 check("rel_pos_first_tick", 64'(px[0]), 64'd91);
        drain(200);

`ifdef SERVO_RAMP_CLAMP_EN
        // Clamped targets: x saturates to POS_MAX
        for (int i = 1; i <= 90; i++) begin
            int xv;
            xv = (91 + i > 180) ? 180 : 91 + i;
            push(0, 16'(xv), 16'(90 - i), 90, (i == 90) ? 1'b0 : 1'b1, (i == 90) ? 1'b1 : 1'b0);
        end
        issue(0, 16'hFFFF, 16'd0, 16'd90);
        drain(1000);
        check("clamp_pos_x", 64'(px[0]), 64'd180);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/servo_ramp.md
# servo_ramp

Three-axis servo slew limiter that sits between the position-select state machine and the three PWM generators. It latches 16-bit target positions and moves each registered output toward its target by at most STEP counts per ramp tick. This keeps abrupt accelerometer or memory-playback jumps from slamming the arm servos. The outputs drive the PWM `data` inputs directly.

## Interface
- TICK_DIV, 50000: clock cycles per ramp tick (1 kHz at 50 MHz); legal range ≥2.
- STEP, 16'd1: maximum position change per axis per tick; must be ≥1.
- RESET_POS, 16'd90: value of every pos_* output after reset.
- POS_MIN, 16'd0: lower clamp bound (only with clamp macro).
- POS_MAX, 16'd180: upper clamp bound (only with clamp macro).

Ports:
- clk  in  1  system clock (MAX10_CLK1_50 at top level).
- rst  in  1  asynchronous, active-low reset (KEY[0] at top level).
- target_x / target_y / target_z  in  16  unsigned target positions.
- target_valid  in  1  one-cycle strobe; all three targets are captured together.
- pos_x / pos_y / pos_z  out  16  registered ramped positions, fed to the PWM blocks.
- busy  out  1  high while in RAMP.
- done  out  1  one-cycle pulse when all three axes reach their targets.

## Operation
- States: IDLE, RAMP. Reset state is IDLE.
- Reset values:
  - pos_* = RESET_POS.
  - Internal targets tgt_* = RESET_POS.
  - busy = 0, done = 0, tick counter = 0.
- Tick counter:
  - Free-running; counts 0..TICK_DIV-1 and wraps to 0.
  - tick is high for one cycle when count == TICK_DIV-1.
  - The counter runs in both states and is never restarted by target_valid.
- target_valid in either state:
  - tgt_* ← target_* (clamped if enabled) on that clock edge.
  - Next state is RAMP.
- RAMP, on tick, per axis independently (unsigned compare):
  - If |tgt - pos| ≤ STEP: pos ← tgt.
  - Else pos ← pos + STEP or pos - STEP toward tgt.
  - No overshoot and no wrap-around. Differences are computed in 17 bits.
- RAMP exit: if after a tick update all three pos == tgt, done pulses on the cycle following the update edge and the state returns to IDLE.
- A target equal to the current pos still enters RAMP; done fires after the next tick.
- Simultaneous tick and target_valid:
  - The tick update uses the old tgt_*; the new targets are latched on the same edge.
  - The state stays RAMP and done is suppressed that cycle, even if the old targets were reached.
- IDLE: pos_* hold; ticks are ignored.
- Reset asserted mid-ramp: all outputs return immediately (asynchronously) to their reset values.

## Timing
- target_valid at edge N: tgt_* valid after edge N; busy = 1 after edge N.
- The first pos change occurs at the first tick edge after N, so latency is 1..TICK_DIV cycles.
- Full traversal of distance D takes ceil(D/STEP) ticks.
- done is registered, high exactly one cycle; busy falls on the same edge done rises.
- pos_* change only on tick edges (or reset) and are glitch-free registered outputs.

## Configuration
- Macro: SERVO_RAMP_CLAMP_EN.
- Defined: each captured target is saturated to [POS_MIN, POS_MAX] before it is stored in tgt_*. RESET_POS must also lie in this range.
- Undefined: targets are stored unmodified; POS_MIN/POS_MAX are unused. The full 16-bit range is legal.

## Test plan
Sim parameters: TICK_DIV=4, STEP=1, RESET_POS=90, POS_MIN=0, POS_MAX=180.
1. Reset: rst low mid-simulation → pos_*=90, busy=0, done=0 immediately; counter restarts from 0 after release.
2. Basic ramp: target_x=93, target_y=90, target_z=88 → pos_x goes 91, 92, 93 and pos_z goes 89, 88 on successive ticks. done pulses once after the 3rd tick; busy=0 afterwards.
3. Overshoot guard with STEP=5: target 92 from 90 → pos goes straight to 92 on the first tick.
4. Retarget mid-ramp: target 100, then after 2 ticks (pos=92) target 85 → pos reverses 91, 90, …, 85 with no done before 85.
5. Simultaneous tick and target_valid on the same cycle: pos uses the old target, the new target is captured, busy stays 1 and done is suppressed.
6. Clamp:
   - With SERVO_RAMP_CLAMP_EN, target 16'hFFFF → pos ramps to 180 and stops.
   - Without it → pos keeps ramping to 65535; no wrap past 16'hFFFF.
